// File: rtl/subbytes_arbiter.sv
// Round-robin arbiter that shares one subbytesstep unit between two ports.
// Latches operands, runs the start/finish handshake and returns results.
module subbytes_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [127:0] in0,
   input  logic [127:0] key0,
   output logic [127:0] out0,
   output logic         done0,
   output logic         err0,
   input  logic         req1,
   input  logic [127:0] in1,
   input  logic [127:0] key1,
   output logic [127:0] out1,
   output logic         done1,
   output logic         err1,
   output logic         step_start,
   output logic [127:0] step_in,
   output logic [127:0] step_key,
   input  logic         step_finish,
   input  logic [127:0] step_result
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t       state, state_d;
   logic         last, last_d;
   logic         gnt, gnt_d;
   logic         sel;
   logic [7:0]   cnt, cnt_d;
   logic [127:0] in_q, in_d;
   logic [127:0] key_q, key_d;
   logic [127:0] out0_d, out1_d;
   logic         done0_d, done1_d;
   logic         err0_d, err1_d;

   assign step_start = (state == RUN);
   assign step_in    = in_q;
   assign step_key   = key_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         gnt   <= 1'b0;
         cnt   <= 8'd0;
         in_q  <= '0;
         key_q <= '0;
         out0  <= '0;
         out1  <= '0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0  <= 1'b0;
         err1  <= 1'b0;
      end else begin
         state <= state_d;
         last  <= last_d;
         gnt   <= gnt_d;
         cnt   <= cnt_d;
         in_q  <= in_d;
         key_q <= key_d;
         out0  <= out0_d;
         out1  <= out1_d;
         done0 <= done0_d;
         done1 <= done1_d;
         err0  <= err0_d;
         err1  <= err1_d;
      end
   end

   always_comb begin
      state_d = state;
      last_d  = last;
      gnt_d   = gnt;
      sel     = 1'b0;
      cnt_d   = cnt;
      in_d    = in_q;
      key_d   = key_q;
      out0_d  = out0;
      out1_d  = out1;
      done0_d = 1'b0;
      done1_d = 1'b0;
      err0_d  = 1'b0;
      err1_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               // on a tie, the port not served last wins
               sel     = (req0 && req1) ? ~last : req1;
               gnt_d   = sel;
               last_d  = sel;
               in_d    = sel ? in1 : in0;
               key_d   = sel ? key1 : key0;
               cnt_d   = 8'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (step_finish) begin
               if (gnt) begin
                  out1_d  = step_result;
                  done1_d = 1'b1;
               end else begin
                  out0_d  = step_result;
                  done0_d = 1'b1;
               end
               state_d = DRAIN;
            end else if (cnt == CNT_LAST) begin
               err0_d  = ~gnt;
               err1_d  = gnt;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         DRAIN: begin
            // a finish level left over from this op must not start the next
            if (!step_finish) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_subbytes_arbiter.sv
// Bench for subbytes_arbiter with a behavioural subbytesstep unit model.
// Expected results go into a queue when requests are driven.
module tb_subbytes_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [127:0] in0 = '0, in1 = '0, key0 = '0, key1 = '0;
   logic [127:0] out0, out1;
   logic         done0, done1, err0, err1;
   logic         step_start;
   logic [127:0] step_in, step_key;
   logic         step_finish = 1'b0;
   logic [127:0] step_result = '0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic         port;
      logic [127:0] val;
   } exp_t;
   exp_t sb[$];
   logic [127:0] last0;

   int lat = 3;
   int stale_hold = 0;
   bit never_finish = 1'b0;
   int st_cnt = 0;
   int hold_cnt = 0;

   always #5 clk = ~clk;

   subbytes_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .in0(in0), .key0(key0),
      .out0(out0), .done0(done0), .err0(err0),
      .req1(req1), .in1(in1), .key1(key1),
      .out1(out1), .done1(done1), .err1(err1),
      .step_start(step_start), .step_in(step_in),
      .step_key(step_key), .step_finish(step_finish),
      .step_result(step_result)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0] r, b, s;
      int e;
      r = 8'h01; b = v; e = 254;
      while (e != 0) begin
         if (e[0]) r = gmul(r, b);
         b = gmul(b, b);
         e = e >> 1;
      end
      s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
            ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] sbox128(input logic [127:0] v);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(v[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // level-sensitive unit model: finish after lat cycles of start,
   // held for stale_hold extra cycles once start falls
   always @(posedge clk) begin
      if (!step_start) begin
         st_cnt <= 0;
         if (step_finish) begin
            if (hold_cnt >= stale_hold) begin
               step_finish <= 1'b0;
               hold_cnt    <= 0;
            end else begin
               hold_cnt <= hold_cnt + 1;
            end
         end
      end else if (!never_finish && !step_finish) begin
         if (st_cnt == lat - 1) begin
            step_finish <= 1'b1;
            step_result <= sbox128(step_in);
            hold_cnt    <= 0;
         end else begin
            st_cnt <= st_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      int n;
      n = int'(done0) + int'(done1) + int'(err0) + int'(err1);
      if (!rst && n > 0) begin
         n_cmp++;
         if (n > 1) begin
            n_bad++;
            $display("FAIL pulse_exclusive: %0d pulses high, want 1", n);
         end
      end
   end

   task automatic wait_evt(input int budget, output int ev);
      ev = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done0) ev = 0;
         else if (done1) ev = 1;
         else if (err0) ev = 2;
         else if (err1) ev = 3;
         if (ev >= 0) break;
      end
   endtask

   task automatic wait_start(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (step_start) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s_start: step_start never rose", nm);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!step_start && !step_finish) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL wait_idle: unit still busy start=%b finish=%b",
                  step_start, step_finish);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (step_start !== 1'b0) begin
         n_bad++; $display("FAIL rst_start: got %b want 0", step_start);
      end
      n_cmp++;
      if (out0 !== '0) begin
         n_bad++; $display("FAIL rst_out0: got %h want 0", out0);
      end
      n_cmp++;
      if (out1 !== '0) begin
         n_bad++; $display("FAIL rst_out1: got %h want 0", out1);
      end
      n_cmp++;
      if (step_in !== '0 || step_key !== '0) begin
         n_bad++;
         $display("FAIL rst_operands: got %h %h want 0", step_in, step_key);
      end
      n_cmp++;
      if ({done0, done1, err0, err1} !== 4'b0) begin
         n_bad++;
         $display("FAIL rst_pulses: got %b want 0000", {done0, done1, err0, err1});
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [127:0] iv, kv;
      exp_t e;
      int ev;
      iv = 128'h2a179373117e3de9969f402ee2bec16b;
      kv = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
      in0 = iv; key0 = kv;
      sb.push_back({1'b0, 128'he5f0dc8f82f3271e90db093198ae787f});
      req0 = 1'b1;
      wait_start("single");
      n_cmp++;
      if (step_in !== iv || step_key !== kv) begin
         n_bad++;
         $display("FAIL single_operands: got %h %h want %h %h", step_in, step_key, iv, kv);
      end
      in0 = ~iv; key0 = '0;
      @(negedge clk);
      n_cmp++;
      if (step_in !== iv || step_key !== kv) begin
         n_bad++;
         $display("FAIL single_latched: got %h %h want %h %h", step_in, step_key, iv, kv);
      end
      wait_evt(40, ev);
      req0 = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (ev !== int'(e.port)) begin
         n_bad++; $display("FAIL single_event: got %0d want %0d", ev, e.port);
      end
      n_cmp++;
      if (out0 !== e.val) begin
         n_bad++; $display("FAIL single_out0: got %h want %h", out0, e.val);
      end
      last0 = e.val;
      n_cmp++;
      if (out1 !== '0) begin
         n_bad++; $display("FAIL single_out1: got %h want 0", out1);
      end
      @(negedge clk);
      n_cmp++;
      if (done0 !== 1'b0) begin
         n_bad++; $display("FAIL single_done_width: got %b want 0", done0);
      end
      wait_idle();
   endtask

   task automatic test_simultaneous();
      exp_t e;
      int ev;
      do_reset();
      key0 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
      key1 = key0;
      in0 = 128'h518eaf45ac6fb79e9cac031e578a2dae;
      in1 = 128'hef520a1a19c1fbe511e45ca3461cc830;
      sb.push_back({1'b0, 128'hd119796e91a8a90bde917b725b7ed8e4});
      sb.push_back({1'b1, 128'hdf0067a2d4780fd982694a0a5a9ce804});
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_evt(60, ev);
         if (ev == 0) req0 = 1'b0;
         if (ev == 1) req1 = 1'b0;
         e = sb.pop_front();
         n_cmp++;
         if (ev !== int'(e.port)) begin
            n_bad++; $display("FAIL simul_order%0d: got %0d want %0d", k, ev, e.port);
         end
         n_cmp++;
         if ((e.port ? out1 : out0) !== e.val) begin
            n_bad++;
            $display("FAIL simul_out%0d: got %h want %h", e.port,
                     e.port ? out1 : out0, e.val);
         end
         if (!e.port) last0 = e.val;
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [127:0] v0[3], v1[3];
      exp_t e;
      int ev, c0, c1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         v0[i] = rnd128();
         v1[i] = rnd128();
      end
      for (int i = 0; i < 6; i++)
         sb.push_back({1'(i % 2), sbox128((i % 2) ? v1[i/2] : v0[i/2])});
      in0 = v0[0]; in1 = v1[0];
      c0 = 0; c1 = 0;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_evt(60, ev);
         e = sb.pop_front();
         n_cmp++;
         if (ev !== int'(e.port)) begin
            n_bad++; $display("FAIL rr_grant%0d: got %0d want %0d", i, ev, e.port);
         end
         n_cmp++;
         if ((e.port ? out1 : out0) !== e.val) begin
            n_bad++;
            $display("FAIL rr_out%0d: got %h want %h", i, e.port ? out1 : out0, e.val);
         end
         if (ev == 0) begin
            c0++;
            last0 = out0;
            if (c0 < 3) in0 = v0[c0];
            else req0 = 1'b0;
         end else if (ev == 1) begin
            c1++;
            if (c1 < 3) in1 = v1[c1];
            else req1 = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      n_cmp++;
      if (c0 != 3 || c1 != 3) begin
         n_bad++; $display("FAIL rr_counts: got %0d/%0d want 3/3", c0, c1);
      end
      wait_idle();
   endtask

   task automatic test_stale_finish();
      exp_t e;
      int ev;
      bit low_seen, rose, bad, got;
      stale_hold = 5;
      in0 = rnd128();
      sb.push_back({1'b0, sbox128(in0)});
      req0 = 1'b1;
      wait_evt(40, ev);
      req0 = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (ev !== 0 || out0 !== e.val) begin
         n_bad++; $display("FAIL stale_first: got %0d %h want 0 %h", ev, out0, e.val);
      end
      last0 = e.val;
      in1 = 128'h10376ce67b412bad179b4fdf45249ff6;
      sb.push_back({1'b1, 128'hca9a508e2183f195f014849e6e36db42});
      req1 = 1'b1;
      low_seen = 1'b0; rose = 1'b0; bad = 1'b0; got = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!step_finish) low_seen = 1'b1;
         if (low_seen && step_finish) rose = 1'b1;
         if (step_start && !low_seen) bad = 1'b1;
         if (done1) begin
            got = 1'b1;
            break;
         end
      end
      req1 = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (!got || bad || !rose) begin
         n_bad++;
         $display("FAIL stale_grant: got done=%b early=%b rise=%b want 1 0 1", got, bad, rose);
      end
      n_cmp++;
      if (out1 !== e.val) begin
         n_bad++; $display("FAIL stale_out1: got %h want %h", out1, e.val);
      end
      stale_hold = 0;
      wait_idle();
   endtask

   task automatic test_timeout();
      int k;
      bit hit, early;
      never_finish = 1'b1;
      in0 = rnd128();
      req0 = 1'b1;
      wait_start("timeout");
      k = 0; hit = 1'b0; early = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         k++;
         if (done0) early = 1'b1;
         if (err0) begin
            hit = 1'b1;
            break;
         end
      end
      req0 = 1'b0;
      n_cmp++;
      if (!hit || k != 8 || early) begin
         n_bad++;
         $display("FAIL timeout_cycles: got err=%b after %0d done=%b want err after 8", hit, k, early);
      end
      n_cmp++;
      if (out0 !== last0) begin
         n_bad++; $display("FAIL timeout_out0: got %h want %h", out0, last0);
      end
      n_cmp++;
      if (step_start !== 1'b0) begin
         n_bad++; $display("FAIL timeout_start: got %b want 0", step_start);
      end
      @(negedge clk);
      n_cmp++;
      if (err0 !== 1'b0) begin
         n_bad++; $display("FAIL timeout_err_width: got %b want 0", err0);
      end
      never_finish = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int ev, pulses;
      in0 = rnd128();
      req0 = 1'b1;
      wait_start("rstmid");
      @(negedge clk);
      rst = 1'b1;
      req0 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (step_start !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_start: got %b want 0", step_start);
      end
      n_cmp++;
      if (out0 !== '0 || out1 !== '0 || step_in !== '0 || step_key !== '0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got %h %h %h %h want 0", out0, out1, step_in, step_key);
      end
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done0 || done1 || err0 || err1) pulses++;
         @(negedge clk);
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++; $display("FAIL rstmid_pulses: got %0d want 0", pulses);
      end
      wait_idle();
      in1 = rnd128();
      sb.push_back({1'b1, sbox128(in1)});
      req1 = 1'b1;
      wait_evt(40, ev);
      req1 = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (ev !== 1 || out1 !== e.val) begin
         n_bad++; $display("FAIL rstmid_next: got %0d %h want 1 %h", ev, out1, e.val);
      end
      wait_idle();
   endtask

   initial begin
      last0 = '0;
      test_reset();
      test_single();
      test_simultaneous();
      test_back_to_back();
      test_stale_finish();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
